// File: rtl/pps_rx.sv
// pps_rx: receive side of the PPS link.
// Synchronises an external 1 PPS input into the aclk domain, detects its
// rising edges, measures each period in aclk cycles, qualifies it against
// the nominal clock rate and tracks lock/loss. While locked it counts
// seconds; bad periods and timeouts are tallied in a saturating error count.
module pps_rx #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned TOL      = 1000,
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        en_i,
  input  logic        pps_in,
  output logic        pps_pulse_o,
  output logic [31:0] period_o,
  output logic        period_vld_o,
  output logic        locked_o,
  output logic        lost_o,
  output logic [31:0] sec_cnt_o,
  output logic [15:0] err_cnt_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_TRACK  = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  // Window of acceptable periods and the count at which a missing edge is
  // declared lost (one past the longest acceptable period).
  localparam logic [31:0] P_MIN = 32'(CLK_FREQ - TOL);
  localparam logic [31:0] P_MAX = 32'(CLK_FREQ + TOL);
  localparam logic [31:0] P_TMO = 32'(CLK_FREQ + TOL + 1);

  // Good-period counter just wide enough to hold LOCK_CNT.
  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_CNT);

  logic          r_s1;
  logic          r_s2;
  logic          r_s3;
  logic [31:0]   r_cnt;
  logic [1:0]    r_state;
  logic [GW-1:0] r_good;
  logic          r_pulse;
  logic [31:0]   r_period;
  logic          r_vld;
  logic          r_locked;
  logic          r_lost;
  logic [31:0]   r_sec;
  logic [15:0]   r_err;

  logic          w_edge;
  logic          w_good;
  logic          w_timeout;
  logic [GW-1:0] w_good_inc;
  logic [1:0]    w_state_next;
  logic [GW-1:0] w_good_next;
  logic          w_meas;
  logic          w_err_inc;
  logic          w_sec_inc;
  logic          w_lost;

  // Three-flop synchroniser; s1 may go metastable, s2/s3 feed edge detect.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= pps_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge     = r_s2 & ~r_s3 & en_i;
  assign w_good     = (r_cnt >= P_MIN) && (r_cnt <= P_MAX);
  assign w_timeout  = (r_cnt >= P_TMO);
  assign w_good_inc = r_good + 1'b1;

  // Next-state and event decode; an edge takes priority over a timeout.
  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good;
    w_meas       = 1'b0;
    w_err_inc    = 1'b0;
    w_sec_inc    = 1'b0;
    w_lost       = 1'b0;
    if (!en_i) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (w_edge) begin
            w_state_next = ST_TRACK;
            w_good_next  = '0;
          end
        end
        ST_TRACK: begin
          if (w_edge) begin
            w_meas = 1'b1;
            if (w_good) begin
              w_good_next = w_good_inc;
              if (w_good_inc == GOOD_TARGET) begin
                w_state_next = ST_LOCKED;
              end
            end else begin
              w_good_next = '0;
              w_err_inc   = 1'b1;
            end
          end else if (w_timeout) begin
            w_lost       = 1'b1;
            w_err_inc    = 1'b1;
            w_state_next = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (w_edge) begin
            w_meas = 1'b1;
            if (w_good) begin
              w_sec_inc = 1'b1;
            end else begin
              w_state_next = ST_TRACK;
              w_good_next  = '0;
              w_err_inc    = 1'b1;
            end
          end else if (w_timeout) begin
            w_lost       = 1'b1;
            w_err_inc    = 1'b1;
            w_state_next = ST_SEARCH;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State, good-period counter and lock flag.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= ST_IDLE;
      r_good   <= '0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_good   <= w_good_next;
      r_locked <= (w_state_next == ST_LOCKED);
    end
  end

  // Cycle counter: reloads to 1 after an edge, saturates, idles at 0.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_cnt <= '0;
    end else if (!en_i || (r_state == ST_IDLE)) begin
      r_cnt <= '0;
    end else if (w_edge) begin
      r_cnt <= 32'd1;
    end else if (r_cnt != 32'hFFFF_FFFF) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  // Single-cycle strobes; cleared whenever the triggering event is absent.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_pulse <= 1'b0;
      r_vld   <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_pulse <= w_edge;
      r_vld   <= w_meas;
      r_lost  <= w_lost;
    end
  end

  // Measurement and statistics; these hold while disabled.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_period <= '0;
      r_sec    <= '0;
      r_err    <= '0;
    end else begin
      if (w_meas) begin
        r_period <= r_cnt;
      end
      if (w_sec_inc) begin
        r_sec <= r_sec + 32'd1;
      end
      if (w_err_inc && (r_err != 16'hFFFF)) begin
        r_err <= r_err + 16'd1;
      end
    end
  end

  assign pps_pulse_o  = r_pulse;
  assign period_o     = r_period;
  assign period_vld_o = r_vld;
  assign locked_o     = r_locked;
  assign lost_o       = r_lost;
  assign sec_cnt_o    = r_sec;
  assign err_cnt_o    = r_err;

endmodule

// File: tb/tb_pps_rx.sv
// tb_pps_rx: scenario tests for pps_rx with a timestamp-based reference
// model. Rising edges of the driven pps_in are remembered as cycle stamps;
// periods are differences of stamps, lock is a streak of in-window periods.
`timescale 1ns/1ps
module tb_pps_rx;

  localparam int CLK_FREQ = 1000;
  localparam int TOL      = 10;
  localparam int LOCK_CNT = 3;
  localparam int TMO      = CLK_FREQ + TOL + 1;

  logic        aclk   = 1'b0;
  logic        areset = 1'b0;
  logic        en_i   = 1'b0;
  logic        pps_in = 1'b0;
  logic        pps_pulse_o;
  logic [31:0] period_o;
  logic        period_vld_o;
  logic        locked_o;
  logic        lost_o;
  logic [31:0] sec_cnt_o;
  logic [15:0] err_cnt_o;

  pps_rx #(
    .CLK_FREQ (CLK_FREQ),
    .TOL      (TOL),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .en_i         (en_i),
    .pps_in       (pps_in),
    .pps_pulse_o  (pps_pulse_o),
    .period_o     (period_o),
    .period_vld_o (period_vld_o),
    .locked_o     (locked_o),
    .lost_o       (lost_o),
    .sec_cnt_o    (sec_cnt_o),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 aclk = ~aclk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  // Reference model state
  typedef enum int {M_OFF, M_HUNT, M_TRACK, M_LOCK} mode_t;
  mode_t       m_mode;
  int          m_streak;
  int          m_last_edge;
  logic        m_prev;
  int          m_rise_q[$];
  logic        e_pulse;
  logic        e_vld;
  logic        e_lost;
  logic [31:0] e_period;
  logic [31:0] e_sec;
  logic [15:0] e_err;

  // Observation counters for scenario checks
  int n_pulse;
  int n_vld;
  int n_lost;
  int last_pulse_cyc;
  int last_lost_cyc;
  int last_rise_cyc;

  task automatic model_reset();
    m_mode      = M_OFF;
    m_streak    = 0;
    m_last_edge = 0;
    m_prev      = 1'b0;
    m_rise_q.delete();
    e_pulse     = 1'b0;
    e_vld       = 1'b0;
    e_lost      = 1'b0;
    e_period    = '0;
    e_sec       = '0;
    e_err       = '0;
  endtask

  task automatic bump_err();
    if (e_err != 16'hFFFF) e_err = e_err + 16'd1;
  endtask

  // A rise sampled at clock c is acted upon at clock c+2 (synchroniser
  // latency) and appears on the outputs after that clock.
  task automatic model_update(input logic pv, input logic ev, input logic rst);
    logic edge_now;
    int   per;
    logic ok;
    if (rst) begin
      model_reset();
      return;
    end
    if (pv && !m_prev) m_rise_q.push_back(cyc + 2);
    m_prev   = pv;
    edge_now = 1'b0;
    if (m_rise_q.size() > 0 && m_rise_q[0] == cyc) begin
      void'(m_rise_q.pop_front());
      edge_now = ev;
    end
    e_pulse = edge_now;
    e_vld   = 1'b0;
    e_lost  = 1'b0;
    if (!ev) begin
      m_mode = M_OFF;
    end else if (m_mode == M_OFF) begin
      m_mode = M_HUNT;
    end else if (m_mode == M_HUNT) begin
      if (edge_now) begin
        m_mode      = M_TRACK;
        m_streak    = 0;
        m_last_edge = cyc;
      end
    end else begin
      if (edge_now) begin
        per         = cyc - m_last_edge;
        m_last_edge = cyc;
        e_vld       = 1'b1;
        e_period    = 32'(per);
        ok          = (per >= CLK_FREQ - TOL) && (per <= CLK_FREQ + TOL);
        if (m_mode == M_LOCK) begin
          if (ok) e_sec = e_sec + 32'd1;
          else begin
            m_mode   = M_TRACK;
            m_streak = 0;
            bump_err();
          end
        end else if (ok) begin
          m_streak = m_streak + 1;
          if (m_streak >= LOCK_CNT) m_mode = M_LOCK;
        end else begin
          m_streak = 0;
          bump_err();
        end
      end else if (cyc - m_last_edge >= TMO) begin
        e_lost = 1'b1;
        bump_err();
        m_mode = M_HUNT;
      end
    end
  endtask

  // One clock of stimulus, scored against the model on the falling edge.
  task automatic drive_cycle(input logic pv);
    logic [83:0] got;
    logic [83:0] exp;
    pps_in = pv;
    @(posedge aclk);
    cyc = cyc + 1;
    model_update(pv, en_i, areset);
    @(negedge aclk);
    got = {pps_pulse_o, period_vld_o, locked_o, lost_o, period_o, sec_cnt_o, err_cnt_o};
    exp = {e_pulse, e_vld, (m_mode == M_LOCK), e_lost, e_period, e_sec, e_err};
    chk_cnt = chk_cnt + 1;
    if (got !== exp)
      $display("FAIL cycle_outputs cyc=%0d got=%h expected=%h", cyc, got, exp);
    else
      pass_cnt = pass_cnt + 1;
    if (pps_pulse_o) begin
      n_pulse        = n_pulse + 1;
      last_pulse_cyc = cyc;
    end
    if (lost_o) begin
      n_lost        = n_lost + 1;
      last_lost_cyc = cyc;
    end
    if (period_vld_o) begin
      n_vld = n_vld + 1;
      $display("txn cyc=%0d period=%0d locked=%0b sec=%0d err=%0d",
               cyc, period_o, locked_o, sec_cnt_o, err_cnt_o);
    end
  endtask

  // One PPS period: rise now, high for h cycles, low for the rest of p.
  task automatic gen_period(input int p, input int h);
    last_rise_cyc = cyc + 1;
    for (int i = 0; i < p; i++) drive_cycle(i < h);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0);
  endtask

  task automatic clear_counts();
    n_pulse = 0;
    n_vld   = 0;
    n_lost  = 0;
  endtask

  task automatic test_reset();
    model_reset();
    areset = 1'b1;
    en_i   = 1'b0;
    for (int i = 0; i < 8; i++) drive_cycle((i % 2) == 1);
    chk_cnt = chk_cnt + 1;
    if ({pps_pulse_o, period_vld_o, locked_o, lost_o, period_o, sec_cnt_o, err_cnt_o} !== 84'd0)
      $display("FAIL reset_outputs got nonzero outputs, required all zero");
    else
      pass_cnt = pass_cnt + 1;
    areset = 1'b0;
    en_i   = 1'b1;
    clear_counts();
    idle(3000);
    chk_cnt = chk_cnt + 1;
    if (n_lost !== 0 || locked_o !== 1'b0)
      $display("FAIL search_no_lost lost_count=%0d locked=%0b required 0/0", n_lost, locked_o);
    else
      pass_cnt = pass_cnt + 1;
  endtask

  task automatic test_lock();
    clear_counts();
    gen_period(CLK_FREQ, $urandom_range(1, 50));
    chk_cnt = chk_cnt + 1;
    if (last_pulse_cyc !== last_rise_cyc + 2)
      $display("FAIL pulse_latency pulse_cyc=%0d required=%0d", last_pulse_cyc, last_rise_cyc + 2);
    else
      pass_cnt = pass_cnt + 1;
    gen_period(CLK_FREQ, $urandom_range(1, 50));
    gen_period(CLK_FREQ, $urandom_range(1, 50));
    chk_cnt = chk_cnt + 1;
    if (locked_o !== 1'b0)
      $display("FAIL lock_early locked=%0b required 0 after edge 3", locked_o);
    else
      pass_cnt = pass_cnt + 1;
    gen_period(CLK_FREQ, $urandom_range(1, 50));
    chk_cnt = chk_cnt + 1;
    if (locked_o !== 1'b1)
      $display("FAIL lock_edge4 locked=%0b required 1", locked_o);
    else
      pass_cnt = pass_cnt + 1;
    gen_period(CLK_FREQ, $urandom_range(1, 50));
    chk_cnt = chk_cnt + 1;
    if (n_pulse !== 5 || n_vld !== 4 || period_o !== 32'd1000 || sec_cnt_o !== 32'd1 || err_cnt_o !== 16'd0)
      $display("FAIL lock_summary pulses=%0d vld=%0d period=%0d sec=%0d err=%0d required 5/4/1000/1/0",
               n_pulse, n_vld, period_o, sec_cnt_o, err_cnt_o);
    else
      pass_cnt = pass_cnt + 1;
  endtask

  task automatic test_bad_period();
    clear_counts();
    idle(11);                                  // stretches the period to 1011
    gen_period(990, $urandom_range(1, 50));
    chk_cnt = chk_cnt + 1;
    if (period_o !== 32'd1011 || locked_o !== 1'b0 || err_cnt_o !== 16'd1 || n_lost !== 0)
      $display("FAIL bad_period period=%0d locked=%0b err=%0d lost=%0d required 1011/0/1/0",
               period_o, locked_o, err_cnt_o, n_lost);
    else
      pass_cnt = pass_cnt + 1;
    gen_period(990, $urandom_range(1, 50));
    gen_period(990, $urandom_range(1, 50));
    gen_period(CLK_FREQ, $urandom_range(1, 50));
    chk_cnt = chk_cnt + 1;
    if (locked_o !== 1'b1 || period_o !== 32'd990 || err_cnt_o !== 16'd1)
      $display("FAIL relock locked=%0b period=%0d err=%0d required 1/990/1", locked_o, period_o, err_cnt_o);
    else
      pass_cnt = pass_cnt + 1;
  endtask

  task automatic test_timeout();
    clear_counts();
    idle(200);
    chk_cnt = chk_cnt + 1;
    if (n_lost !== 1 || last_lost_cyc !== last_rise_cyc + 2 + TMO)
      $display("FAIL lost_pulse count=%0d at=%0d required 1 at %0d", n_lost, last_lost_cyc, last_rise_cyc + 2 + TMO);
    else
      pass_cnt = pass_cnt + 1;
    chk_cnt = chk_cnt + 1;
    if (locked_o !== 1'b0 || err_cnt_o !== 16'd2)
      $display("FAIL lost_state locked=%0b err=%0d required 0/2", locked_o, err_cnt_o);
    else
      pass_cnt = pass_cnt + 1;
    clear_counts();
    gen_period(CLK_FREQ, $urandom_range(1, 50));
    chk_cnt = chk_cnt + 1;
    if (n_vld !== 0 || n_pulse !== 1)
      $display("FAIL search_edge vld=%0d pulses=%0d required 0/1", n_vld, n_pulse);
    else
      pass_cnt = pass_cnt + 1;
  endtask

  task automatic test_wide_boundary();
    int err0;
    err0 = int'(err_cnt_o);
    clear_counts();
    gen_period(CLK_FREQ, 500);
    gen_period(CLK_FREQ, 500);
    gen_period(CLK_FREQ, 500);
    gen_period(1010, 500);
    gen_period(1011, 500);
    chk_cnt = chk_cnt + 1;
    if (period_o !== 32'd1010 || locked_o !== 1'b1)
      $display("FAIL boundary_1010 period=%0d locked=%0b required 1010/1", period_o, locked_o);
    else
      pass_cnt = pass_cnt + 1;
    gen_period(CLK_FREQ, 500);
    chk_cnt = chk_cnt + 1;
    if (period_o !== 32'd1011 || locked_o !== 1'b0 || int'(err_cnt_o) !== err0 + 1)
      $display("FAIL boundary_1011 period=%0d locked=%0b err=%0d required 1011/0/%0d",
               period_o, locked_o, err_cnt_o, err0 + 1);
    else
      pass_cnt = pass_cnt + 1;
    chk_cnt = chk_cnt + 1;
    if (n_pulse !== 6)
      $display("FAIL wide_pulses pulses=%0d required 6", n_pulse);
    else
      pass_cnt = pass_cnt + 1;
  endtask

  task automatic test_random();
    int p;
    int h;
    for (int k = 0; k < 15; k++) begin
      if ($urandom_range(0, 9) == 0) p = 1100;
      else p = $urandom_range(CLK_FREQ - 15, CLK_FREQ + 15);
      h = $urandom_range(1, p - 1);
      gen_period(p, h);
    end
  endtask

  task automatic test_enable_reset();
    logic [31:0] sec0;
    logic [31:0] per0;
    logic [15:0] err0;
    for (int k = 0; k < 4; k++) gen_period(CLK_FREQ, $urandom_range(1, 100));
    gen_period(300, 50);
    chk_cnt = chk_cnt + 1;
    if (locked_o !== 1'b1)
      $display("FAIL pre_disable_lock locked=%0b required 1", locked_o);
    else
      pass_cnt = pass_cnt + 1;
    sec0 = sec_cnt_o;
    err0 = err_cnt_o;
    per0 = period_o;
    en_i = 1'b0;
    drive_cycle(1'b0);
    chk_cnt = chk_cnt + 1;
    if (locked_o !== 1'b0)
      $display("FAIL disable_unlock locked=%0b required 0", locked_o);
    else
      pass_cnt = pass_cnt + 1;
    clear_counts();
    gen_period(CLK_FREQ, 100);
    gen_period(CLK_FREQ, 100);
    chk_cnt = chk_cnt + 1;
    if (n_pulse !== 0 || n_vld !== 0 || n_lost !== 0 || sec_cnt_o !== sec0 || err_cnt_o !== err0 || period_o !== per0)
      $display("FAIL disabled_hold pulses=%0d vld=%0d lost=%0d sec=%0d err=%0d period=%0d required 0/0/0/%0d/%0d/%0d",
               n_pulse, n_vld, n_lost, sec_cnt_o, err_cnt_o, period_o, sec0, err0, per0);
    else
      pass_cnt = pass_cnt + 1;
    en_i = 1'b1;
    gen_period(500, 100);
    #2;
    areset = 1'b1;
    #1;
    chk_cnt = chk_cnt + 1;
    if ({pps_pulse_o, period_vld_o, locked_o, lost_o, period_o, sec_cnt_o, err_cnt_o} !== 84'd0)
      $display("FAIL async_reset period=%0d sec=%0d err=%0d locked=%0b required all zero",
               period_o, sec_cnt_o, err_cnt_o, locked_o);
    else
      pass_cnt = pass_cnt + 1;
    for (int i = 0; i < 3; i++) drive_cycle(1'b0);
    areset = 1'b0;
    gen_period(CLK_FREQ, 200);
    gen_period(CLK_FREQ, 200);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_bad_period();
    test_timeout();
    test_wide_boundary();
    test_random();
    test_enable_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
